// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the cache refill engine.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } refill_state_e;

  localparam int unsigned DEF_XLEN      = 32;
  localparam int unsigned DEF_LINE_SIZE = 64;

  // Number of bus beats needed to move one line.
  function automatic int unsigned beats(input int unsigned xlen, input int unsigned line_size);
    return line_size / (xlen / 8);
  endfunction

  // Beat index width; clamped to 1 so single-beat lines still get a valid vector.
  function automatic int unsigned beat_w(input int unsigned xlen, input int unsigned line_size);
    int unsigned n;
    n = beats(xlen, line_size);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-offset width within a line.
  function automatic int unsigned line_off_w(input int unsigned line_size);
    return $clog2(line_size);
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// Line register with whole-line load and beat-indexed slice write/read.
module cache_line_buf
  import cache_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned LINE_SIZE = DEF_LINE_SIZE
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   i_load,
  input  logic [8*LINE_SIZE-1:0]                 i_load_line,
  input  logic                                   i_wr,
  input  logic [beat_w(XLEN, LINE_SIZE)-1:0]     i_wr_idx,
  input  logic [XLEN-1:0]                        i_wr_data,
  input  logic [beat_w(XLEN, LINE_SIZE)-1:0]     i_rd_idx,
  output logic [XLEN-1:0]                        o_rd_data,
  output logic [8*LINE_SIZE-1:0]                 o_line
);

  logic [8*LINE_SIZE-1:0] r_line;

  // Load takes priority; it only happens on request acceptance when no beat write can occur.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_load_line;
    end else if (i_wr) begin
      r_line[i_wr_idx*XLEN +: XLEN] <= i_wr_data;
    end
  end

  assign o_rd_data = r_line[i_rd_idx*XLEN +: XLEN];
  assign o_line    = r_line;

endmodule

// File: rtl/cache_refill.sv
// Cache line refill / write-back engine.
// Optional feature macro: CACHE_REFILL_CRITICAL_FIRST_EN (fill starts at the missed beat and wraps).
module cache_refill
  import cache_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned LINE_SIZE = DEF_LINE_SIZE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [XLEN-1:0]        req_addr,
  output logic                   req_ready,
  input  logic                   wb_valid,
  input  logic [XLEN-1:0]        wb_addr,
  input  logic [8*LINE_SIZE-1:0] wb_line,
  output logic [XLEN-1:0]        mem_addr,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [XLEN-1:0]        mem_wdata,
  input  logic [XLEN-1:0]        mem_rdata,
  input  logic                   mem_ack,
  output logic                   fill_en,
  output logic [XLEN-1:0]        fill_addr,
  output logic [8*LINE_SIZE-1:0] fill_line,
  output logic                   done
);

  localparam int unsigned BEATS  = beats(XLEN, LINE_SIZE);
  localparam int unsigned BEAT_W = beat_w(XLEN, LINE_SIZE);
  localparam int unsigned OFF_W  = line_off_w(LINE_SIZE);
  localparam int unsigned BYTE_W = $clog2(XLEN / 8);

  refill_state_e     r_state;
  logic [BEAT_W-1:0] r_beat;     // beat currently on the bus
  logic [BEAT_W-1:0] r_cnt;      // acks taken in the current phase
  logic [BEAT_W-1:0] r_start;    // first fill beat
  logic [XLEN-1:0]   r_req_line;
  logic [XLEN-1:0]   r_wb_line_addr;
  logic              r_req_ready;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_fill_en;
  logic              r_done;

  logic              w_accept;
  logic              w_last;
  logic [BEAT_W-1:0] w_start;
  logic [XLEN-1:0]   w_beat_off;
  logic [XLEN-1:0]   w_rd_data;
  logic              w_unused_addr;

  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_last     = (r_cnt == BEAT_W'(BEATS - 1));
  assign w_beat_off = XLEN'(r_beat) << BYTE_W;

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
  assign w_start = req_addr[BYTE_W +: BEAT_W];
`else
  assign w_start = '0;
`endif

  // Line offset bits only matter for the critical-first start beat.
  assign w_unused_addr = ^{req_addr[OFF_W-1:0], wb_addr[OFF_W-1:0]};

  // Refill sequencer: state, beat counters, latched addresses and registered control outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_beat         <= '0;
      r_cnt          <= '0;
      r_start        <= '0;
      r_req_line     <= '0;
      r_wb_line_addr <= '0;
      r_req_ready    <= 1'b1;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_fill_en      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req_line     <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            r_wb_line_addr <= {wb_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            r_start        <= w_start;
            r_cnt          <= '0;
            r_req_ready    <= 1'b0;
            if (wb_valid) begin
              r_state     <= WB;
              r_beat      <= '0;
              r_mem_write <= 1'b1;
            end else begin
              r_state     <= FILL;
              r_beat      <= w_start;
              r_mem_read  <= 1'b1;
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            if (w_last) begin
              r_state     <= FILL;
              r_beat      <= r_start;
              r_cnt       <= '0;
              r_mem_write <= 1'b0;
              r_mem_read  <= 1'b1;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
              r_cnt  <= r_cnt + BEAT_W'(1);
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (w_last) begin
              r_state    <= COMMIT;
              r_beat     <= '0;
              r_cnt      <= '0;
              r_mem_read <= 1'b0;
              r_fill_en  <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              // Natural wrap of the index gives modulo-BEATS order for critical-first.
              r_beat <= r_beat + BEAT_W'(1);
              r_cnt  <= r_cnt + BEAT_W'(1);
            end
          end
        end
        COMMIT: begin
          r_state     <= IDLE;
          r_fill_en   <= 1'b0;
          r_done      <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_fill_en   <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // The buffer holds the victim during WB, then each fill beat overwrites its slice.
  cache_line_buf #(
    .XLEN      (XLEN),
    .LINE_SIZE (LINE_SIZE)
  ) u_line_buf (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_accept),
    .i_load_line (wb_line),
    .i_wr        ((r_state == FILL) && mem_ack),
    .i_wr_idx    (r_beat),
    .i_wr_data   (mem_rdata),
    .i_rd_idx    (r_beat),
    .o_rd_data   (w_rd_data),
    .o_line      (fill_line)
  );

  // Bus address/data are decoded from registered state only; zero when no beat is active.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_mem_write) begin
      mem_addr  = r_wb_line_addr + w_beat_off;
      mem_wdata = w_rd_data;
    end else if (r_mem_read) begin
      mem_addr  = r_req_line + w_beat_off;
    end
  end

  assign req_ready = r_req_ready;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign fill_en   = r_fill_en;
  assign done      = r_done;
  assign fill_addr = r_req_line;

endmodule

// File: tb/tb_cache_refill.sv
// Directed self-checking bench for cache_refill (honours CACHE_REFILL_CRITICAL_FIRST_EN).
module tb_cache_refill;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned LINE_SIZE = 64;
  localparam int unsigned BEATS     = 16;
  localparam int unsigned LW        = 8 * LINE_SIZE;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid;
  logic [31:0]     req_addr;
  logic            req_ready;
  logic            wb_valid;
  logic [31:0]     wb_addr;
  logic [LW-1:0]   wb_line;
  logic [31:0]     mem_addr;
  logic            mem_read;
  logic            mem_write;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic            mem_ack;
  logic            fill_en;
  logic [31:0]     fill_addr;
  logic [LW-1:0]   fill_line;
  logic            done;

  logic [LW-1:0]   wb_pat;
  int              n_vec  = 0;
  int              n_miss = 0;

  cache_refill #(
    .XLEN      (XLEN),
    .LINE_SIZE (LINE_SIZE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_line   (wb_line),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .fill_en   (fill_en),
    .fill_addr (fill_addr),
    .fill_line (fill_line),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents model: each word derived from its own address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [LW-1:0] exp_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int b = 0; b < BEATS; b++) l[b*32 +: 32] = mem_val(base + 32'(4 * b));
    return l;
  endfunction

  function automatic logic [LW-1:0] mk_wb_line();
    logic [LW-1:0] l;
    for (int b = 0; b < BEATS; b++) l[b*32 +: 32] = 32'hD000_0000 + 32'(b) * 32'h0000_0111;
    return l;
  endfunction

  task automatic issue(input logic [31:0] a, input logic wbv, input logic [31:0] wa);
    @(negedge clock);
    check_val("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    wb_valid  = wbv;
    wb_addr   = wa;
    wb_line   = wb_pat;
  endtask

  // Drive the bus side of one refill and check every beat, the commit and the return to idle.
  task automatic run(input logic [31:0] a, input logic wbv, input logic [31:0] wa,
                     input bit stall, input bit hold);
    int          cyc = 0;
    int          wi  = 0;
    int          ri  = 0;
    int          start;
    bit          seen = 0;
    logic [31:0] base;
    logic [31:0] ea;
    base = {a[31:6], 6'b0};
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    start = int'(a[5:2]);
`else
    start = 0;
`endif
    while (!seen && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (!hold) req_valid = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      check_val("rw_exclusive", mem_read & mem_write, 0);
      check_val("busy_not_ready", req_ready, 0);
      if (mem_write) begin
        check_val("wb_addr", mem_addr, wa + 32'(4 * wi));
        check_val("wb_data", mem_wdata, wb_pat[wi*32 +: 32]);
        mem_ack = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (mem_ack) wi++;
      end else if (mem_read) begin
        ea = base + 32'(4 * ((start + ri) % BEATS));
        check_val("wb_done_before_fill", wi, wbv ? BEATS : 0);
        check_val("fill_beat_addr", mem_addr, ea);
        mem_ack = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (mem_ack) begin
          mem_rdata = mem_val(ea);
          ri++;
        end
      end else if (fill_en) begin
        seen = 1;
        check_val("commit_done", done, 1);
        check_val("commit_fill_addr", fill_addr, base);
        check_val("commit_line", fill_line, exp_line(base));
        check_val("commit_read_count", ri, BEATS);
        if (!stall) check_val("commit_cycle", cyc, wbv ? 33 : 17);
      end else begin
        check_val("active_when_busy", mem_read | mem_write | fill_en, 1);
      end
    end
    if (!seen) check_val("refill_timeout", seen, 1);
    @(negedge clock);
    mem_ack = 1'b0;
    check_val("commit_one_cycle", fill_en, 0);
    check_val("done_one_cycle", done, 0);
    check_val("ready_after_commit", req_ready, 1);
  endtask

  initial begin
    bit fill_seen;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_line   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    wb_pat    = mk_wb_line();

    #12;
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_ctrl", {mem_read, mem_write, fill_en, done}, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_fill_addr", fill_addr, 0);
    check_val("rst_fill_line", fill_line, 0);
    @(negedge clock);
    reset = 1'b0;

    // Clean miss, ack every cycle.
    issue(32'h0000_1044, 1'b0, 32'h0);
    run(32'h0000_1044, 1'b0, 32'h0, 1'b0, 1'b0);

    // Dirty miss: write-back of victim then fill.
    issue(32'h0000_1044, 1'b1, 32'h0000_2000);
    run(32'h0000_1044, 1'b1, 32'h0000_2000, 1'b0, 1'b0);

    // Random ack gaps, clean and dirty.
    issue(32'h0000_1044, 1'b0, 32'h0);
    run(32'h0000_1044, 1'b0, 32'h0, 1'b1, 1'b0);
    issue(32'h0000_3010, 1'b1, 32'h0000_2000);
    run(32'h0000_3010, 1'b1, 32'h0000_2000, 1'b1, 1'b0);

    // Reset mid-fill at beat 7.
    issue(32'h0000_1044, 1'b0, 32'h0);
    @(negedge clock);
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    for (int g = 0; g < 40 && !(mem_read && mem_addr == 32'h0000_105C); g++) begin
      mem_rdata = mem_val(mem_addr);
      @(negedge clock);
    end
    check_val("reached_beat7", {mem_read, mem_addr}, {1'b1, 32'h0000_105C});
    mem_ack = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_val("mid_rst_ready", req_ready, 1);
    check_val("mid_rst_ctrl", {mem_read, mem_write, fill_en, done}, 0);
    check_val("mid_rst_mem_addr", mem_addr, 0);
    check_val("mid_rst_fill_line", fill_line, 0);
    @(negedge clock);
    reset     = 1'b0;
    fill_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (fill_en) fill_seen = 1;
    end
    check_val("no_fill_after_rst", fill_seen, 0);
    issue(32'h0000_1044, 1'b0, 32'h0);
    run(32'h0000_1044, 1'b0, 32'h0, 1'b0, 1'b0);

    // Critical-first request (linear order when the feature is off).
    issue(32'h0000_1054, 1'b0, 32'h0);
    run(32'h0000_1054, 1'b0, 32'h0, 1'b0, 1'b0);

    // req_valid held through a busy refill: one acceptance per return to idle.
    issue(32'h0000_4020, 1'b0, 32'h0);
    run(32'h0000_4020, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    run(32'h0000_4020, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    check_val("no_extra_accept", {req_ready, mem_read, mem_write}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
